// File: rtl/ras_predictor_if.sv
// ras_predictor_if: bundle between the BPU front end (master) and the
// return-address-stack stage (slave).
//
// Handshake: there is no back-pressure on this bus. A BTB prediction is
// accepted on every rising edge where BtbNextAble=1 and RasStop=0. A result
// is valid in the cycle after the edge that sampled it, while PredAble=1.
// RasStop=1 drops that cycle's BTB input and freezes every output.
//
// Signals:
//   master -> slave : RasStop, RasFlash, BtbNextAble, BtbHitBank, BtbNextPc,
//                     BtbNextType, BlockPc, CommitCallAble, CommitRetAddr,
//                     CommitRetAble
//   slave -> master : PredAble, PredPc, PredType, PredFromRas, RasCount
interface ras_predictor_if #(
  parameter int PTR_W = 3
) ();
  logic             RasStop;
  logic             RasFlash;
  logic             BtbNextAble;
  logic [1:0]       BtbHitBank;
  logic [31:0]      BtbNextPc;
  logic [2:0]       BtbNextType;
  logic [31:0]      BlockPc;
  logic             CommitCallAble;
  logic [31:0]      CommitRetAddr;
  logic             CommitRetAble;
  logic             PredAble;
  logic [31:0]      PredPc;
  logic [2:0]       PredType;
  logic             PredFromRas;
  logic [PTR_W:0]   RasCount;

  modport master (
    output RasStop, RasFlash, BtbNextAble, BtbHitBank, BtbNextPc, BtbNextType,
           BlockPc, CommitCallAble, CommitRetAddr, CommitRetAble,
    input  PredAble, PredPc, PredType, PredFromRas, RasCount
  );

  modport slave (
    input  RasStop, RasFlash, BtbNextAble, BtbHitBank, BtbNextPc, BtbNextType,
           BlockPc, CommitCallAble, CommitRetAddr, CommitRetAble,
    output PredAble, PredPc, PredType, PredFromRas, RasCount
  );
endinterface

// File: rtl/ras_predictor.sv
// ras_predictor: return-address stack stage sitting behind the BTB.
// It pushes the fall-through block address on an active CALL, substitutes
// the top-of-stack on an active RETURN, and registers the final next-PC
// prediction one cycle after sampling.
//
// Ports:
//   Clk  - clock
//   Rest - synchronous, active-high reset
//   bus  - ras_predictor_if.slave (BTB inputs, stall/flush, retire, outputs)
//
// Optional feature macro: RAS_COMMIT_STACK_EN
//   defined   : a committed stack tracks retired CALL/RETURN; RasFlash copies
//               it (including the same-cycle commit) into the speculative one.
//   undefined : commit inputs are ignored; RasFlash empties the speculative
//               stack (contents stay in the array but become unreachable).
module ras_predictor #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           Clk,
  input  logic           Rest,
  ras_predictor_if.slave bus
);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [2:0] TYPE_CALL   = 3'd2;
  localparam logic [2:0] TYPE_RETURN = 3'd3;

  // Speculative stack
  logic [31:0]      spec_mem_q [DEPTH];
  logic [PTR_W-1:0] spec_top_q, spec_top_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;

  // Registered outputs
  logic        pred_able_q, pred_able_d;
  logic [31:0] pred_pc_q, pred_pc_d;
  logic [2:0]  pred_type_q, pred_type_d;
  logic        pred_from_ras_q, pred_from_ras_d;

  logic        active, is_call, is_ret;
  logic        push_en;
  logic [31:0] push_addr;

  assign active    = bus.BtbNextAble && (bus.BtbHitBank != 2'b00);
  assign is_call   = active && (bus.BtbNextType == TYPE_CALL);
  assign is_ret    = active && (bus.BtbNextType == TYPE_RETURN);
  // Fall-through of a 32-byte fetch block: next aligned block address.
  assign push_addr = {bus.BlockPc[31:5], 5'd0} + 32'd32;

  always_comb begin
    spec_top_d      = spec_top_q;
    spec_cnt_d      = spec_cnt_q;
    push_en         = 1'b0;
    pred_able_d     = 1'b0;
    pred_pc_d       = '0;
    pred_type_d     = '0;
    pred_from_ras_d = 1'b0;
    if (bus.BtbNextAble) begin
      pred_able_d = 1'b1;
      pred_pc_d   = bus.BtbNextPc;
      pred_type_d = bus.BtbNextType;
    end
    if (is_call) begin
      push_en    = 1'b1;
      spec_top_d = spec_top_q + 1'b1;
      // On overflow the top keeps wrapping and the oldest entry is lost.
      if (spec_cnt_q != CNT_FULL) spec_cnt_d = spec_cnt_q + 1'b1;
    end else if (is_ret && (spec_cnt_q != '0)) begin
      pred_pc_d       = spec_mem_q[spec_top_q - 1'b1];
      pred_from_ras_d = 1'b1;
      spec_top_d      = spec_top_q - 1'b1;
      spec_cnt_d      = spec_cnt_q - 1'b1;
    end
  end

`ifdef RAS_COMMIT_STACK_EN
  // Committed stack, advanced only by retire.
  logic [31:0]      com_mem_q [DEPTH];
  logic [31:0]      com_mem_d [DEPTH];
  logic [PTR_W-1:0] com_top_q, com_top_d;
  logic [CNT_W-1:0] com_cnt_q, com_cnt_d;

  // The *_d values double as the flush source so a commit in the flush
  // cycle is already included in the restored state.
  always_comb begin
    com_mem_d = com_mem_q;
    com_top_d = com_top_q;
    com_cnt_d = com_cnt_q;
    if (bus.CommitCallAble) begin
      // Push wins over a simultaneous (illegal) pop.
      com_mem_d[com_top_q] = bus.CommitRetAddr;
      com_top_d            = com_top_q + 1'b1;
      if (com_cnt_q != CNT_FULL) com_cnt_d = com_cnt_q + 1'b1;
    end else if (bus.CommitRetAble && (com_cnt_q != '0)) begin
      com_top_d = com_top_q - 1'b1;
      com_cnt_d = com_cnt_q - 1'b1;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{bus.CommitCallAble, bus.CommitRetAddr, bus.CommitRetAble};
`endif

  logic unused_blk_lsb;
  assign unused_blk_lsb = ^bus.BlockPc[4:0];

  always_ff @(posedge Clk) begin
    if (Rest) begin
      for (int i = 0; i < DEPTH; i++) spec_mem_q[i] <= '0;
      spec_top_q      <= '0;
      spec_cnt_q      <= '0;
      pred_able_q     <= 1'b0;
      pred_pc_q       <= '0;
      pred_type_q     <= '0;
      pred_from_ras_q <= 1'b0;
`ifdef RAS_COMMIT_STACK_EN
      for (int i = 0; i < DEPTH; i++) com_mem_q[i] <= '0;
      com_top_q <= '0;
      com_cnt_q <= '0;
`endif
    end else begin
`ifdef RAS_COMMIT_STACK_EN
      // Retire is never stalled or flushed.
      com_mem_q <= com_mem_d;
      com_top_q <= com_top_d;
      com_cnt_q <= com_cnt_d;
`endif
      // Stall outranks flush: a flush seen during a stall is dropped.
      if (!bus.RasStop) begin
        if (bus.RasFlash) begin
          pred_able_q     <= 1'b0;
          pred_pc_q       <= '0;
          pred_type_q     <= '0;
          pred_from_ras_q <= 1'b0;
`ifdef RAS_COMMIT_STACK_EN
          spec_mem_q <= com_mem_d;
          spec_top_q <= com_top_d;
          spec_cnt_q <= com_cnt_d;
`else
          spec_top_q <= '0;
          spec_cnt_q <= '0;
`endif
        end else begin
          pred_able_q     <= pred_able_d;
          pred_pc_q       <= pred_pc_d;
          pred_type_q     <= pred_type_d;
          pred_from_ras_q <= pred_from_ras_d;
          spec_top_q      <= spec_top_d;
          spec_cnt_q      <= spec_cnt_d;
          if (push_en) spec_mem_q[spec_top_q] <= push_addr;
        end
      end
    end
  end

  assign bus.PredAble    = pred_able_q;
  assign bus.PredPc      = pred_pc_q;
  assign bus.PredType    = pred_type_q;
  assign bus.PredFromRas = pred_from_ras_q;
  assign bus.RasCount    = spec_cnt_q;
endmodule

// File: doc/ras_predictor.md
# ras_predictor

Return-address stack stage directly downstream of the BTB in the BPU. Each cycle it takes the BTB's registered next-PC/type/hit-bank prediction for the current 32-byte fetch block. It pushes the fall-through block address on CALL and substitutes the stacked address on RETURN. It emits the final predicted next fetch PC one cycle later. A committed copy of the stack, fed from retire, repairs the speculative stack on flush.

## Interface
Parameters:
- DEPTH, 8: stack entries; power of two, 2..64.
- PTR_W, 3: log2(DEPTH).

Ports:
- Clk  in  1  clock.
- Rest  in  1  reset; synchronous, active-high.
- RasStop  in  1  pipeline stall: hold all state and outputs.
- RasFlash  in  1  redirect: clear outputs, repair speculative stack.
- BtbNextAble  in  1  BTB prediction valid this cycle.
- BtbHitBank  in  2  BTB hit bank; 2'b00 = miss.
- BtbNextPc  in  32  BTB predicted target.
- BtbNextType  in  3  BTB branch type. Codes: 0 FORMAL, 1 BRANCH, 2 CALL, 3 RETURN, 4 JUMP.
- BlockPc  in  32  fetch-block PC aligned with the BTB output; bits [4:0] ignored.
- CommitCallAble  in  1  a CALL retired.
- CommitRetAddr  in  32  return address of the retired CALL.
- CommitRetAble  in  1  a RETURN retired.
- PredAble  out  1  prediction valid.
- PredPc  out  32  final predicted next fetch PC.
- PredType  out  3  type passed through from BTB.
- PredFromRas  out  1  PredPc came from the stack.
- RasCount  out  PTR_W+1  speculative stack occupancy.

## Operation
- Speculative stack: DEPTH x 32 circular array, top pointer SpecTop (PTR_W bits, wraps), count SpecCnt (0..DEPTH).
- A prediction is "active" when BtbNextAble=1 and BtbHitBank!=0.
- Priority per cycle: Rest > RasStop > RasFlash > normal.
- Normal operation, active CALL:
  - Write ({BlockPc[31:5],5'd0}+32) to stack[SpecTop].
  - SpecTop+1 mod DEPTH; SpecCnt saturates at DEPTH.
  - Overflow overwrites the oldest entry silently.
  - PredPc=BtbNextPc.
- Normal operation, active RETURN:
  - If SpecCnt>0: PredPc=stack[SpecTop-1 mod DEPTH]; pop (SpecTop-1, SpecCnt-1); PredFromRas=1.
  - If SpecCnt=0: PredPc=BtbNextPc; PredFromRas=0; no pointer change.
- All other cases with BtbNextAble=1: PredPc=BtbNextPc; PredType=BtbNextType; stack unchanged.
- BtbNextAble=0: PredAble=0, PredPc=0, PredType=0, PredFromRas=0.
- Committed stack: identical structure (ComTop, ComCnt), updated only by retire.
  - CommitCallAble pushes CommitRetAddr.
  - CommitRetAble pops; a pop when ComCnt=0 is ignored.
  - Commit updates are independent of RasStop and RasFlash.
  - CommitCallAble and CommitRetAble together is illegal; the push takes effect and the pop is ignored.
- RasFlash: repair per Configuration. Outputs cleared to reset values.

## Timing
- Latency 1 cycle: inputs sampled at edge N, PredPc valid after edge N, stack updated at edge N.
- Reset values:
  - Outputs: PredAble=0, PredPc=0, PredType=0, PredFromRas=0, RasCount=0.
  - Pointers and counts: 0; array contents: 0.
- RasStop=1: outputs, SpecTop, SpecCnt and the speculative array all hold; BTB input that cycle is dropped.
- RasFlash concurrent with a commit: the restore uses the committed state including that cycle's commit (bypass).
- RasStop concurrent with RasFlash: stop wins; the flash is lost. Upstream must hold RasFlash until stop drops.
- RasCount is registered and reflects the state after the last edge.

## Configuration
- RAS_COMMIT_STACK_EN defined:
  - Committed stack instantiated.
  - RasFlash copies the whole committed array, ComTop and ComCnt into the speculative stack in one cycle.
- RAS_COMMIT_STACK_EN undefined:
  - No committed stack; commit inputs ignored.
  - RasFlash resets SpecTop=0 and SpecCnt=0; array contents retained but unreachable.

## Test plan
- Reset then CALL with BlockPc=0x1C00_0044, BtbNextPc=0x1C00_2000, hit 01 -> next cycle PredPc=0x1C00_2000, RasCount=1. A later RETURN with hit 10 and BtbNextPc=0xDEAD_0000 -> PredPc=0x1C00_0060, PredFromRas=1, RasCount=0.
- RETURN with empty stack, BtbNextPc=0x1C00_3000 -> PredPc=0x1C00_3000, PredFromRas=0, RasCount stays 0.
- DEPTH+1 CALLs from BlockPc 0x100, 0x200, ... -> RasCount=DEPTH. DEPTH RETURNs pop 0x(DEPTH+1)20 down to 0x220; the next RETURN falls back to the BTB target.
- RasStop high for 3 cycles with active CALLs on the input -> outputs frozen at prior values, RasCount unchanged.
- With the macro: commit 2 CALLs (0xA0, 0xB0), speculative 3 CALLs, then RasFlash -> RasCount=2, and the next RETURN predicts 0xB0. Without the macro: same stimulus -> RasCount=0.
- CALL with BtbHitBank=00 -> no push; PredPc=BtbNextPc.
